// File: rtl/sqrt_add_stage_hs.sv
// ---------------------------------------------------------------------------
// sqrt_add_stage_hs
//
// Final register stage of the square-root pipeline's split adder. It adds the
// high halves of the two operands plus the carry out of the low half, joins
// the result with the already-computed low-half sum, and presents it (with
// the sideband flags) behind a valid/ready handshake.
//
// Parameters
//   LOW_W   width of the low-half sum input
//   HIGH_W  width of the high-half operands
//   SB_W    sideband width, carried through untouched
//   SKID    1: two-entry skid buffer with a registered in_ready_o
//           0: single register, in_ready_o is combinational
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous reset, active-high
//   flush_i      synchronous flush of every held entry
//   in_valid_i   upstream beat valid
//   in_ready_o   stage can accept a beat this cycle
//   sb_i         sideband flags of the incoming beat
//   sum_low_i    low-half sum from the previous stage
//   co_i         carry out of the low half
//   a_high_i     operand A high half
//   b_high_i     operand B high half
//   out_valid_o  head entry valid
//   out_ready_i  downstream accepts the head entry
//   sb_o         sideband of the head entry
//   sum_o        {a_high + b_high + co, sum_low} of the head entry
// ---------------------------------------------------------------------------
module sqrt_add_stage_hs #(
    parameter int LOW_W  = 8,
    parameter int HIGH_W = 9,
    parameter int SB_W   = 3,
    parameter int SKID   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [SB_W-1:0]          sb_i,
    input  logic [LOW_W-1:0]         sum_low_i,
    input  logic                     co_i,
    input  logic [HIGH_W-1:0]        a_high_i,
    input  logic [HIGH_W-1:0]        b_high_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [SB_W-1:0]          sb_o,
    output logic [HIGH_W+LOW_W:0]    sum_o
);

    localparam int SUM_W  = HIGH_W + LOW_W + 1;
    localparam int DATA_W = SB_W + SUM_W;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t              state_reg;
    state_t              state_next;
    logic [DATA_W-1:0]   main_reg;
    logic [DATA_W-1:0]   skid_reg;
    logic [HIGH_W:0]     hi_sum;
    logic [DATA_W-1:0]   in_data;
    logic                accept;
    logic                emit;
    logic                load_main;
    logic                load_skid;
    logic                move_skid;

    // High-half sum is one bit wider than the operands so the carry out of
    // the top is always kept: 2*(2^HIGH_W-1)+1 still fits in HIGH_W+1 bits.
    assign hi_sum  = {1'b0, a_high_i} + {1'b0, b_high_i} + {{HIGH_W{1'b0}}, co_i};
    assign in_data = {sb_i, hi_sum, sum_low_i};

    assign out_valid_o = (state_reg != ST_EMPTY);
    assign sb_o        = main_reg[DATA_W-1 -: SB_W];
    assign sum_o       = main_reg[SUM_W-1:0];

    assign accept = in_valid_i & in_ready_o;
    assign emit   = out_valid_o & out_ready_i;

    generate
        if (SKID != 0) begin : g_skid
            // Ready comes straight from a flop so there is no combinational
            // path from out_ready_i to in_ready_o. It is computed from the
            // next state, so it is already correct in the cycle the state
            // changes. The flush term only masks it while flush is asserted.
            logic ready_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ready_reg <= 1'b0;
                end else begin
                    ready_reg <= (state_next != ST_TWO);
                end
            end

            assign in_ready_o = ready_reg & ~flush_i;
        end else begin : g_noskid
            // Holds ready low while reset is applied and releases it on the
            // first edge afterwards.
            logic alive_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    alive_reg <= 1'b0;
                end else begin
                    alive_reg <= 1'b1;
                end
            end

            assign in_ready_o = alive_reg & ~flush_i & (out_ready_i | ~out_valid_o);
        end
    endgenerate

    // Occupancy state machine. With SKID=0 the ONE->TWO arc is unreachable:
    // an accept in ONE implies out_ready_i, hence an emit in the same cycle.
    always_comb begin
        state_next = state_reg;
        load_main  = 1'b0;
        load_skid  = 1'b0;
        move_skid  = 1'b0;
        if (flush_i) begin
            // Flush wins over accept and emit; data registers keep stale
            // contents, only occupancy is cleared.
            state_next = ST_EMPTY;
        end else begin
            case (state_reg)
                ST_EMPTY: begin
                    if (accept) begin
                        state_next = ST_ONE;
                        load_main  = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && !emit) begin
                        state_next = ST_TWO;
                        load_skid  = 1'b1;
                    end else if (accept && emit) begin
                        state_next = ST_ONE;
                        load_main  = 1'b1;
                    end else if (emit) begin
                        state_next = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (emit) begin
                        state_next = ST_ONE;
                        move_skid  = 1'b1;
                    end
                end
                default: begin
                    state_next = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    // Data registers are cleared by reset so sb_o/sum_o read zero at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_reg <= '0;
            skid_reg <= '0;
        end else begin
            if (load_main) begin
                main_reg <= in_data;
            end else if (move_skid) begin
                main_reg <= skid_reg;
            end
            if (load_skid) begin
                skid_reg <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_sqrt_add_stage_hs.sv
// ---------------------------------------------------------------------------
// tb_sqrt_add_stage_hs
//
// Directed bench for sqrt_add_stage_hs. One instance uses the skid buffer
// (SKID=1), a second uses the single-register variant (SKID=0). Inputs are
// driven on the falling edge and outputs are read 1 time unit later, well
// away from the rising edge where the DUT updates.
// ---------------------------------------------------------------------------
module tb_sqrt_add_stage_hs;

    logic        clk;
    logic        rst;

    // SKID=1 instance signals
    logic        flush1;
    logic        in_valid1;
    logic        in_ready1;
    logic [2:0]  sb_in1;
    logic [7:0]  low1;
    logic        co1;
    logic [8:0]  a1;
    logic [8:0]  b1;
    logic        out_valid1;
    logic        out_ready1;
    logic [2:0]  sb_out1;
    logic [17:0] sum1;

    // SKID=0 instance signals
    logic        flush0;
    logic        in_valid0;
    logic        in_ready0;
    logic [2:0]  sb_in0;
    logic [7:0]  low0;
    logic        co0;
    logic [8:0]  a0;
    logic [8:0]  b0;
    logic        out_valid0;
    logic        out_ready0;
    logic [2:0]  sb_out0;
    logic [17:0] sum0;

    int pass_cnt;
    int total_cnt;

    sqrt_add_stage_hs #(.LOW_W(8), .HIGH_W(9), .SB_W(3), .SKID(1)) u_dut1 (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush1),
        .in_valid_i  (in_valid1),
        .in_ready_o  (in_ready1),
        .sb_i        (sb_in1),
        .sum_low_i   (low1),
        .co_i        (co1),
        .a_high_i    (a1),
        .b_high_i    (b1),
        .out_valid_o (out_valid1),
        .out_ready_i (out_ready1),
        .sb_o        (sb_out1),
        .sum_o       (sum1)
    );

    sqrt_add_stage_hs #(.LOW_W(8), .HIGH_W(9), .SB_W(3), .SKID(0)) u_dut0 (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush0),
        .in_valid_i  (in_valid0),
        .in_ready_o  (in_ready0),
        .sb_i        (sb_in0),
        .sum_low_i   (low0),
        .co_i        (co0),
        .a_high_i    (a0),
        .b_high_i    (b0),
        .out_valid_o (out_valid0),
        .out_ready_i (out_ready0),
        .sb_o        (sb_out0),
        .sum_o       (sum0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference arithmetic: 10-bit high sum keeps the top carry.
    function automatic logic [17:0] exp_sum(input logic [8:0] a, input logic [8:0] b,
                                            input logic co, input logic [7:0] low);
        logic [9:0] hi;
        hi = {1'b0, a} + {1'b0, b} + {9'd0, co};
        return {hi, low};
    endfunction

    task automatic drive1(input logic v, input logic [2:0] sb, input logic [7:0] low,
                          input logic co, input logic [8:0] a, input logic [8:0] b);
        in_valid1 = v;
        sb_in1    = sb;
        low1      = low;
        co1       = co;
        a1        = a;
        b1        = b;
    endtask

    // ---------------------------------------------------------------------
    task automatic test_reset();
        @(negedge clk);
        #1;
        total_cnt++;
        if (out_valid1 !== 1'b0) $display("FAIL reset_valid1 got=%b want=0", out_valid1);
        else pass_cnt++;
        total_cnt++;
        if (sum1 !== 18'h0) $display("FAIL reset_sum1 got=%h want=0", sum1);
        else pass_cnt++;
        total_cnt++;
        if (sb_out1 !== 3'h0) $display("FAIL reset_sb1 got=%h want=0", sb_out1);
        else pass_cnt++;
        total_cnt++;
        if (in_ready1 !== 1'b0) $display("FAIL reset_ready1 got=%b want=0", in_ready1);
        else pass_cnt++;
        total_cnt++;
        if (in_ready0 !== 1'b0) $display("FAIL reset_ready0 got=%b want=0", in_ready0);
        else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
        #1;
        total_cnt++;
        if (in_ready1 !== 1'b1) $display("FAIL release_ready1 got=%b want=1", in_ready1);
        else pass_cnt++;
        total_cnt++;
        if (in_ready0 !== 1'b1) $display("FAIL release_ready0 got=%b want=1", in_ready0);
        else pass_cnt++;
        $display("test_reset done");
    endtask

    // ---------------------------------------------------------------------
    task automatic test_arith();
        out_ready1 = 1'b1;
        @(negedge clk);
        drive1(1'b1, 3'd5, 8'hA5, 1'b1, 9'h1FF, 9'h1FF);
        @(negedge clk);
        drive1(1'b1, 3'd2, 8'h00, 1'b0, 9'h000, 9'h000);
        #1;
        total_cnt++;
        if (out_valid1 !== 1'b1 || sum1 !== 18'h3FFA5 || sb_out1 !== 3'd5)
            $display("FAIL arith_max got v=%b sum=%h sb=%h want v=1 sum=3ffa5 sb=5",
                     out_valid1, sum1, sb_out1);
        else pass_cnt++;
        @(negedge clk);
        drive1(1'b0, 3'd0, 8'h00, 1'b0, 9'h000, 9'h000);
        #1;
        total_cnt++;
        if (out_valid1 !== 1'b1 || sum1 !== 18'h0 || sb_out1 !== 3'd2)
            $display("FAIL arith_zero got v=%b sum=%h sb=%h want v=1 sum=0 sb=2",
                     out_valid1, sum1, sb_out1);
        else pass_cnt++;
        @(negedge clk);
        #1;
        total_cnt++;
        if (out_valid1 !== 1'b0) $display("FAIL arith_drain got v=%b want=0", out_valid1);
        else pass_cnt++;
        $display("test_arith done");
    endtask

    // ---------------------------------------------------------------------
    task automatic test_back_to_back();
        logic [17:0] exp_q [0:99];
        logic [2:0]  exp_sb [0:99];
        int          errs;
        errs = 0;
        out_ready1 = 1'b1;
        for (int i = 0; i <= 100; i++) begin
            @(negedge clk);
            if (i < 100) begin
                logic [8:0] a;
                logic [8:0] b;
                logic [7:0] l;
                a = 9'((i * 5) % 512);
                b = 9'(511 - i);
                l = 8'(i * 3);
                exp_q[i]  = exp_sum(a, b, 1'(i), l);
                exp_sb[i] = 3'(i);
                drive1(1'b1, 3'(i), l, 1'(i), a, b);
            end else begin
                drive1(1'b0, 3'd0, 8'd0, 1'b0, 9'd0, 9'd0);
            end
            #1;
            if (i < 100) begin
                total_cnt++;
                if (in_ready1 !== 1'b1) begin
                    $display("FAIL b2b_ready beat=%0d got=%b want=1", i, in_ready1);
                    errs++;
                end else pass_cnt++;
            end
            if (i > 0) begin
                total_cnt++;
                if (out_valid1 !== 1'b1 || sum1 !== exp_q[i-1] || sb_out1 !== exp_sb[i-1]) begin
                    $display("FAIL b2b_data beat=%0d got v=%b sum=%h sb=%h want v=1 sum=%h sb=%h",
                             i - 1, out_valid1, sum1, sb_out1, exp_q[i-1], exp_sb[i-1]);
                    errs++;
                end else pass_cnt++;
            end
        end
        @(negedge clk);
        #1;
        total_cnt++;
        if (out_valid1 !== 1'b0) $display("FAIL b2b_drain got v=%b want=0", out_valid1);
        else pass_cnt++;
        $display("test_back_to_back done beats=100 errors=%0d", errs);
    endtask

    // ---------------------------------------------------------------------
    task automatic test_backpressure();
        out_ready1 = 1'b0;
        @(negedge clk);
        drive1(1'b1, 3'd1, 8'h11, 1'b0, 9'h001, 9'h010);   // beat 1 -> 0x01100+... see expects
        #1;
        total_cnt++;
        if (in_ready1 !== 1'b1) $display("FAIL bp_ready_b1 got=%b want=1", in_ready1);
        else pass_cnt++;
        @(negedge clk);
        drive1(1'b1, 3'd2, 8'h22, 1'b1, 9'h100, 9'h0FF);   // beat 2
        #1;
        total_cnt++;
        if (in_ready1 !== 1'b1) $display("FAIL bp_ready_b2 got=%b want=1", in_ready1);
        else pass_cnt++;
        total_cnt++;
        if (out_valid1 !== 1'b1 || sum1 !== 18'h01111) // hi = 0x001+0x010 = 0x011
            $display("FAIL bp_head1 got v=%b sum=%h want v=1 sum=01111", out_valid1, sum1);
        else pass_cnt++;
        @(negedge clk);
        drive1(1'b1, 3'd3, 8'h33, 1'b0, 9'h1FF, 9'h001);   // beat 3
        for (int k = 0; k < 3; k++) begin
            #1;
            total_cnt++;
            if (in_ready1 !== 1'b0) $display("FAIL bp_full_ready cyc=%0d got=%b want=0", k, in_ready1);
            else pass_cnt++;
            total_cnt++;
            if (out_valid1 !== 1'b1 || sum1 !== 18'h01111 || sb_out1 !== 3'd1)
                $display("FAIL bp_stable cyc=%0d got v=%b sum=%h sb=%h want v=1 sum=01111 sb=1",
                         k, out_valid1, sum1, sb_out1);
            else pass_cnt++;
            @(negedge clk);
        end
        out_ready1 = 1'b1;
        @(negedge clk);
        #1;
        total_cnt++;
        // hi = 0x100+0x0FF+1 = 0x200
        if (out_valid1 !== 1'b1 || sum1 !== 18'h20022 || sb_out1 !== 3'd2)
            $display("FAIL bp_order2 got v=%b sum=%h sb=%h want v=1 sum=20022 sb=2",
                     out_valid1, sum1, sb_out1);
        else pass_cnt++;
        total_cnt++;
        if (in_ready1 !== 1'b1) $display("FAIL bp_ready_after got=%b want=1", in_ready1);
        else pass_cnt++;
        @(negedge clk);
        drive1(1'b0, 3'd0, 8'd0, 1'b0, 9'd0, 9'd0);
        #1;
        total_cnt++;
        // hi = 0x1FF+0x001 = 0x200
        if (out_valid1 !== 1'b1 || sum1 !== 18'h20033 || sb_out1 !== 3'd3)
            $display("FAIL bp_order3 got v=%b sum=%h sb=%h want v=1 sum=20033 sb=3",
                     out_valid1, sum1, sb_out1);
        else pass_cnt++;
        @(negedge clk);
        #1;
        total_cnt++;
        if (out_valid1 !== 1'b0) $display("FAIL bp_drain got v=%b want=0", out_valid1);
        else pass_cnt++;
        $display("test_backpressure done");
    endtask

    // ---------------------------------------------------------------------
    task automatic test_flush();
        out_ready1 = 1'b0;
        @(negedge clk);
        drive1(1'b1, 3'd4, 8'h44, 1'b0, 9'h004, 9'h004);
        @(negedge clk);
        drive1(1'b1, 3'd5, 8'h55, 1'b0, 9'h005, 9'h005);
        @(negedge clk);
        drive1(1'b1, 3'd6, 8'h66, 1'b0, 9'h006, 9'h006);
        flush1 = 1'b1;
        #1;
        total_cnt++;
        if (in_ready1 !== 1'b0) $display("FAIL flush_ready got=%b want=0", in_ready1);
        else pass_cnt++;
        @(negedge clk);
        flush1 = 1'b0;
        drive1(1'b1, 3'd7, 8'h77, 1'b1, 9'h007, 9'h007);
        #1;
        total_cnt++;
        if (out_valid1 !== 1'b0) $display("FAIL flush_valid got=%b want=0", out_valid1);
        else pass_cnt++;
        total_cnt++;
        if (in_ready1 !== 1'b1) $display("FAIL flush_ready_after got=%b want=1", in_ready1);
        else pass_cnt++;
        @(negedge clk);
        drive1(1'b0, 3'd0, 8'd0, 1'b0, 9'd0, 9'd0);
        out_ready1 = 1'b1;
        #1;
        total_cnt++;
        // hi = 7+7+1 = 0x00F
        if (out_valid1 !== 1'b1 || sum1 !== 18'h00F77 || sb_out1 !== 3'd7)
            $display("FAIL flush_next got v=%b sum=%h sb=%h want v=1 sum=00f77 sb=7",
                     out_valid1, sum1, sb_out1);
        else pass_cnt++;
        @(negedge clk);
        #1;
        total_cnt++;
        if (out_valid1 !== 1'b0) $display("FAIL flush_alone got v=%b want=0", out_valid1);
        else pass_cnt++;
        $display("test_flush done");
    endtask

    // ---------------------------------------------------------------------
    task automatic test_reset_midstream();
        out_ready1 = 1'b0;
        @(negedge clk);
        drive1(1'b1, 3'd1, 8'h81, 1'b0, 9'h0AA, 9'h055);
        @(negedge clk);
        drive1(1'b1, 3'd2, 8'h82, 1'b0, 9'h0AA, 9'h055);
        @(negedge clk);
        drive1(1'b0, 3'd0, 8'd0, 1'b0, 9'd0, 9'd0);
        #1;
        total_cnt++;
        if (out_valid1 !== 1'b1 || in_ready1 !== 1'b0)
            $display("FAIL mid_full got v=%b rdy=%b want v=1 rdy=0", out_valid1, in_ready1);
        else pass_cnt++;
        #1;
        rst = 1'b1;   // between edges: effect must be immediate
        #1;
        total_cnt++;
        if (out_valid1 !== 1'b0 || sum1 !== 18'h0 || sb_out1 !== 3'h0)
            $display("FAIL mid_reset got v=%b sum=%h sb=%h want v=0 sum=0 sb=0",
                     out_valid1, sum1, sb_out1);
        else pass_cnt++;
        total_cnt++;
        if (in_ready1 !== 1'b0) $display("FAIL mid_reset_ready got=%b want=0", in_ready1);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        total_cnt++;
        if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0)
            $display("FAIL mid_release got rdy=%b v=%b want rdy=1 v=0", in_ready1, out_valid1);
        else pass_cnt++;
        $display("test_reset_midstream done");
    endtask

    // ---------------------------------------------------------------------
    task automatic test_skid0_random();
        logic [20:0] q [$];
        logic [20:0] head;
        logic        pend;
        int          n_emit;
        int          errs;
        pend   = 1'b0;
        n_emit = 0;
        errs   = 0;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            if (!pend) begin
                in_valid0 = ($urandom_range(0, 3) != 0);
                sb_in0    = 3'($urandom);
                low0      = 8'($urandom);
                co0       = 1'($urandom);
                a0        = 9'($urandom);
                b0        = 9'($urandom);
            end
            out_ready0 = ($urandom_range(0, 3) != 0);
            #1;
            total_cnt++;
            if (out_valid0 !== (q.size() != 0)) begin
                $display("FAIL s0_valid cyc=%0d got=%b want=%b", c, out_valid0, q.size() != 0);
                errs++;
            end else pass_cnt++;
            total_cnt++;
            if (in_ready0 !== (out_ready0 | (q.size() == 0))) begin
                $display("FAIL s0_ready cyc=%0d got=%b want=%b", c, in_ready0,
                         out_ready0 | (q.size() == 0));
                errs++;
            end else pass_cnt++;
            if (out_valid0 && out_ready0 && q.size() != 0) begin
                head = q.pop_front();
                n_emit++;
                total_cnt++;
                if ({sb_out0, sum0} !== head) begin
                    $display("FAIL s0_data cyc=%0d got sb=%h sum=%h want sb=%h sum=%h",
                             c, sb_out0, sum0, head[20:18], head[17:0]);
                    errs++;
                end else pass_cnt++;
            end
            if (in_valid0 && in_ready0)
                q.push_back({sb_in0, exp_sum(a0, b0, co0, low0)});
            pend = in_valid0 & ~in_ready0;
        end
        @(negedge clk);
        in_valid0  = 1'b0;
        out_ready0 = 1'b0;
        total_cnt++;
        if (n_emit < 1000) $display("FAIL s0_throughput got=%0d want>=1000", n_emit);
        else pass_cnt++;
        $display("test_skid0_random done emitted=%0d errors=%0d", n_emit, errs);
    endtask

    // ---------------------------------------------------------------------
    initial begin
        pass_cnt   = 0;
        total_cnt  = 0;
        rst        = 1'b1;
        flush1     = 1'b0;
        out_ready1 = 1'b0;
        drive1(1'b0, 3'd0, 8'd0, 1'b0, 9'd0, 9'd0);
        flush0     = 1'b0;
        in_valid0  = 1'b0;
        out_ready0 = 1'b0;
        sb_in0     = 3'd0;
        low0       = 8'd0;
        co0        = 1'b0;
        a0         = 9'd0;
        b0         = 9'd0;

        test_reset();
        test_arith();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_midstream();
        test_skid0_random();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
